// File: rtl/spart_req_arbiter.sv
// Round-robin arbiter that sequences two word requesters onto the SPART driver
// data port, handshaking against the driver status register with a wait timeout.
module spart_req_arbiter #(
    parameter logic [19:0] TIMEOUT = 20'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_wr,
    input  logic [31:0] r0_wdata,
    output logic        r0_ack,
    output logic [31:0] r0_rdata,
    output logic        r0_err,
    input  logic        r1_req,
    input  logic        r1_wr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic [31:0] r1_rdata,
    output logic        r1_err,
    output logic        spart_data_wren,
    output logic        spart_data_rden,
    output logic [31:0] data_tx,
    input  logic [31:0] data_rx,
    input  logic [31:0] status_register,
    output logic        clear_status_rd,
    output logic        grant,
    output logic        busy
);
    typedef enum logic [3:0] {
        IDLE, TX_WAIT_RDY, TX_STROBE, TX_WAIT_BUSY, TX_WAIT_DONE,
        RX_WAIT_AVAIL, RX_STROBE, RX_CAPTURE, RESP
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_tx_q, data_tx_d;
    logic [31:0] r0_rdata_q, r0_rdata_d;
    logic [31:0] r1_rdata_q, r1_rdata_d;
    logic        pick;
    logic        timeout;
    logic [29:0] status_unused;

    assign status_unused = status_register[31:2];
    assign timeout = (cnt_q == TIMEOUT - 20'd1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 20'd1;
        err_d        = err_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wdata_d      = wdata_q;
        data_tx_d    = data_tx_q;
        r0_rdata_d   = r0_rdata_q;
        r1_rdata_d   = r1_rdata_q;
        pick         = 1'b0;
        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    // On a tie the port that did not win last time goes first.
                    pick         = (r0_req && r1_req) ? ~last_grant_q : r1_req;
                    grant_d      = pick;
                    last_grant_d = pick;
                    wdata_d      = pick ? r1_wdata : r0_wdata;
                    err_d        = 1'b0;
                    cnt_d        = '0;
                    state_d      = (pick ? r1_wr : r0_wr) ? TX_WAIT_RDY : RX_WAIT_AVAIL;
                end
            end
            TX_WAIT_RDY: begin
                if (status_register[0]) begin
                    state_d   = TX_STROBE;
                    data_tx_d = wdata_q;
                end else if (timeout) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            TX_STROBE: begin
                state_d = TX_WAIT_BUSY;
                cnt_d   = '0;
            end
            TX_WAIT_BUSY: begin
                if (!status_register[0]) begin
                    state_d = TX_WAIT_DONE;
                    cnt_d   = '0;
                end else if (timeout) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            TX_WAIT_DONE: begin
                if (status_register[0]) begin
                    state_d = RESP;
                end else if (timeout) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            RX_WAIT_AVAIL: begin
                if (status_register[1]) begin
                    state_d = RX_STROBE;
                end else if (timeout) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            RX_STROBE: state_d = RX_CAPTURE;
            RX_CAPTURE: begin
                if (grant_q) r1_rdata_d = data_rx;
                else         r0_rdata_d = data_rx;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wdata_q      <= '0;
            data_tx_q    <= '0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wdata_q      <= wdata_d;
            data_tx_q    <= data_tx_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
        end
    end

    assign spart_data_wren = (state_q == TX_STROBE);
    assign spart_data_rden = (state_q == RX_STROBE);
    assign clear_status_rd = (state_q == RX_STROBE);
    assign data_tx         = data_tx_q;
    assign r0_ack          = (state_q == RESP) && !grant_q;
    assign r1_ack          = (state_q == RESP) && grant_q;
    assign r0_err          = r0_ack && err_q;
    assign r1_err          = r1_ack && err_q;
    assign r0_rdata        = r0_rdata_q;
    assign r1_rdata        = r1_rdata_q;
    assign grant           = grant_q;
    assign busy            = (state_q != IDLE);
endmodule
